// File: rtl/br_resolve_unit_pkg.sv
// Shared types for the branch-resolution transmit path: state encoding, widths, queue entry.
`ifndef BR_MASK_W
`define BR_MASK_W 5
`endif
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif

package br_resolve_unit_pkg;

  localparam int unsigned BR_MASK_W  = `BR_MASK_W;
  localparam int unsigned BR_STATE_W = `BR_STATE_W;
  localparam int unsigned PC_W       = 64;
  localparam int unsigned STAT_W     = 32;

  typedef enum logic [BR_STATE_W-1:0] {
    BR_NONE       = 2'b00,
    BR_PR_CORRECT = 2'b01,
    BR_PR_WRONG   = 2'b10
  } br_state_e;

  typedef struct packed {
    logic                 valid;
    logic [BR_MASK_W-1:0] dep_mask;
    logic [BR_MASK_W-1:0] own_bit;
    logic                 wrong;
    logic [PC_W-1:0]      npc;
  } br_res_entry_t;

endpackage

// File: rtl/br_mispredict_cmp.sv
// Decides whether a resolved branch was mispredicted and computes its correct next PC.
module br_mispredict_cmp
  import br_resolve_unit_pkg::*;
(
  input  logic            pred_taken,
  input  logic [PC_W-1:0] pred_target,
  input  logic            taken,
  input  logic [PC_W-1:0] target,
  input  logic [PC_W-1:0] fallthru,
  output logic            wrong_c,
  output logic [PC_W-1:0] npc_c
);

  // A target mismatch only matters when the branch was actually taken.
  assign wrong_c = (pred_taken != taken) || (taken && (pred_target != target));
  assign npc_c   = taken ? target : fallthru;

endmodule

// File: rtl/br_resolve_unit.sv
// Branch-resolution transmit side: in-order queue with mask-clear/squash, one issue per cycle.
// Optional BR_RESOLVE_STATS_EN adds saturating correct/wrong/squash counters.
module br_resolve_unit
  import br_resolve_unit_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  input  logic [BR_MASK_W-1:0]  ex_dep_mask_i,
  input  logic [BR_MASK_W-1:0]  ex_own_bit_i,
  input  logic                  ex_pred_taken_i,
  input  logic [PC_W-1:0]       ex_pred_target_i,
  input  logic                  ex_taken_i,
  input  logic [PC_W-1:0]       ex_target_i,
  input  logic [PC_W-1:0]       ex_fallthru_i,
  output logic                  ex_ready_o,
  output logic [BR_STATE_W-1:0] branch_state_o,
  output logic [BR_MASK_W-1:0]  branch_dep_mask_o,
  output logic [BR_MASK_W-1:0]  branch_bit_o,
  output logic                  redirect_valid_o,
  output logic [PC_W-1:0]       redirect_pc_o
`ifdef BR_RESOLVE_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_correct_o,
  output logic [STAT_W-1:0]     stat_wrong_o,
  output logic [STAT_W-1:0]     stat_squash_o
`endif
);

  localparam int unsigned IDX_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  br_res_entry_t    q   [QUEUE_DEPTH];
  br_res_entry_t    q_n [QUEUE_DEPTH];
  br_res_entry_t    head;
  br_res_entry_t    ent;
  br_res_entry_t    in_ent;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic [CNT_W-1:0] keep_cnt;
  logic [CNT_W-1:0] kill_cnt;
  logic             issue;
  logic             head_wrong;
  logic             head_correct;
  logic             in_kill;
  logic             enq;
  logic             cmp_wrong;
  logic [PC_W-1:0]  cmp_npc;

  br_mispredict_cmp u_cmp (
    .pred_taken  (ex_pred_taken_i),
    .pred_target (ex_pred_target_i),
    .taken       (ex_taken_i),
    .target      (ex_target_i),
    .fallthru    (ex_fallthru_i),
    .wrong_c     (cmp_wrong),
    .npc_c       (cmp_npc)
  );

  // Queue is kept compacted, so the head always lives in slot 0.
  assign head         = q[0];
  assign issue        = head.valid;
  assign head_wrong   = issue && head.wrong;
  assign head_correct = issue && !head.wrong;
  assign ex_ready_o   = (count < CNT_W'(QUEUE_DEPTH));

  assign branch_state_o    = !issue     ? BR_NONE :
                             head.wrong ? BR_PR_WRONG : BR_PR_CORRECT;
  assign branch_dep_mask_o = issue ? head.dep_mask : '0;
  assign branch_bit_o      = issue ? head.own_bit  : '0;
  assign redirect_valid_o  = head_wrong;
  assign redirect_pc_o     = head_wrong ? head.npc : '0;

  // Next queue image: pop head, clear or squash on its own bit, compact, append incoming.
  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) q_n[i] = '0;
    keep_cnt = '0;
    kill_cnt = '0;
    ent      = '0;

    for (int i = 1; i < QUEUE_DEPTH; i++) begin
      ent = q[i];
      if (ent.valid) begin
        if (head_wrong && ((ent.dep_mask & head.own_bit) != '0)) begin
          kill_cnt = kill_cnt + CNT_W'(1);
        end else begin
          if (head_correct) ent.dep_mask = ent.dep_mask & ~head.own_bit;
          q_n[keep_cnt[IDX_W-1:0]] = ent;
          keep_cnt = keep_cnt + CNT_W'(1);
        end
      end
    end

    in_ent.valid    = 1'b1;
    in_ent.dep_mask = head_correct ? (ex_dep_mask_i & ~head.own_bit) : ex_dep_mask_i;
    in_ent.own_bit  = ex_own_bit_i;
    in_ent.wrong    = cmp_wrong;
    in_ent.npc      = cmp_npc;

    in_kill = head_wrong && ((ex_dep_mask_i & head.own_bit) != '0);
    enq     = ex_valid_i && ex_ready_o && !in_kill;
    if (enq) q_n[keep_cnt[IDX_W-1:0]] = in_ent;

    count_n = keep_cnt + CNT_W'(enq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) q[i] <= '0;
    end else begin
      count <= count_n;
      for (int i = 0; i < QUEUE_DEPTH; i++) q[i] <= q_n[i];
    end
  end

`ifdef BR_RESOLVE_STATS_EN
  localparam int unsigned SUM_W = STAT_W + 1;

  logic [CNT_W-1:0] squash_inc;
  logic [SUM_W-1:0] squash_sum;

  assign squash_inc = kill_cnt + CNT_W'(in_kill && ex_valid_i && ex_ready_o);
  assign squash_sum = SUM_W'(stat_squash_o) + SUM_W'(squash_inc);

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_correct_o <= '0;
      stat_wrong_o   <= '0;
      stat_squash_o  <= '0;
    end else begin
      if (head_correct && (stat_correct_o != '1)) stat_correct_o <= stat_correct_o + STAT_W'(1);
      if (head_wrong && (stat_wrong_o != '1))     stat_wrong_o   <= stat_wrong_o + STAT_W'(1);
      stat_squash_o <= squash_sum[STAT_W] ? '1 : squash_sum[STAT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_br_resolve_unit.sv
// Self-checking bench for br_resolve_unit: directed vector table plus queue-model random run.
module tb_br_resolve_unit;
  import br_resolve_unit_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NVEC  = 17;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  ex_valid_i;
  logic [BR_MASK_W-1:0]  ex_dep_mask_i;
  logic [BR_MASK_W-1:0]  ex_own_bit_i;
  logic                  ex_pred_taken_i;
  logic [PC_W-1:0]       ex_pred_target_i;
  logic                  ex_taken_i;
  logic [PC_W-1:0]       ex_target_i;
  logic [PC_W-1:0]       ex_fallthru_i;
  logic                  ex_ready_o;
  logic [BR_STATE_W-1:0] branch_state_o;
  logic [BR_MASK_W-1:0]  branch_dep_mask_o;
  logic [BR_MASK_W-1:0]  branch_bit_o;
  logic                  redirect_valid_o;
  logic [PC_W-1:0]       redirect_pc_o;

  always #5 clk = ~clk;

  br_resolve_unit #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_valid_i        (ex_valid_i),
    .ex_dep_mask_i     (ex_dep_mask_i),
    .ex_own_bit_i      (ex_own_bit_i),
    .ex_pred_taken_i   (ex_pred_taken_i),
    .ex_pred_target_i  (ex_pred_target_i),
    .ex_taken_i        (ex_taken_i),
    .ex_target_i       (ex_target_i),
    .ex_fallthru_i     (ex_fallthru_i),
    .ex_ready_o        (ex_ready_o),
    .branch_state_o    (branch_state_o),
    .branch_dep_mask_o (branch_dep_mask_o),
    .branch_bit_o      (branch_bit_o),
    .redirect_valid_o  (redirect_valid_o),
    .redirect_pc_o     (redirect_pc_o)
  );

  typedef struct {
    logic                 rst;
    logic                 valid;
    logic [BR_MASK_W-1:0] dep;
    logic [BR_MASK_W-1:0] own;
    logic                 pt;
    logic [PC_W-1:0]      ptgt;
    logic                 t;
    logic [PC_W-1:0]      tgt;
    logic [PC_W-1:0]      ft;
  } stim_t;

  typedef struct {
    stim_t                 s;
    logic [BR_STATE_W-1:0] st;
    logic [BR_MASK_W-1:0]  dep;
    logic [BR_MASK_W-1:0]  bb;
    logic                  rv;
    logic [PC_W-1:0]       pc;
  } vec_t;

  typedef struct {
    logic [BR_MASK_W-1:0] dep;
    logic [BR_MASK_W-1:0] own;
    logic                 wrong;
    logic [PC_W-1:0]      npc;
  } mentry_t;

  int      errors = 0;
  int      checks = 0;
  vec_t    tbl [NVEC];
  mentry_t mq [$];

  task automatic chk(input string name, input logic [PC_W-1:0] act, input logic [PC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_all(input string tag, input logic [BR_STATE_W-1:0] st,
                         input logic [BR_MASK_W-1:0] dep, input logic [BR_MASK_W-1:0] bb,
                         input logic rv, input logic [PC_W-1:0] pc, input logic rdy);
    chk({tag, ".state"}, PC_W'(branch_state_o), PC_W'(st));
    chk({tag, ".dep"},   PC_W'(branch_dep_mask_o), PC_W'(dep));
    chk({tag, ".bit"},   PC_W'(branch_bit_o), PC_W'(bb));
    chk({tag, ".rv"},    PC_W'(redirect_valid_o), PC_W'(rv));
    chk({tag, ".pc"},    redirect_pc_o, pc);
    chk({tag, ".ready"}, PC_W'(ex_ready_o), PC_W'(rdy));
  endtask

  function automatic stim_t mk_s(input logic r, input logic v, input logic [BR_MASK_W-1:0] dep,
                                 input logic [BR_MASK_W-1:0] own, input logic pt,
                                 input logic [PC_W-1:0] ptgt, input logic t,
                                 input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] ft);
    stim_t s;
    s.rst = r; s.valid = v; s.dep = dep; s.own = own;
    s.pt = pt; s.ptgt = ptgt; s.t = t; s.tgt = tgt; s.ft = ft;
    return s;
  endfunction

  function automatic stim_t idle_s(input logic r);
    return mk_s(r, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
  endfunction

  function automatic vec_t mk_v(input stim_t s, input logic [BR_STATE_W-1:0] st,
                                input logic [BR_MASK_W-1:0] dep, input logic [BR_MASK_W-1:0] bb,
                                input logic rv, input logic [PC_W-1:0] pc);
    vec_t v;
    v.s = s; v.st = st; v.dep = dep; v.bb = bb; v.rv = rv; v.pc = pc;
    return v;
  endfunction

  task automatic apply(input stim_t s);
    rst              = s.rst;
    ex_valid_i       = s.valid;
    ex_dep_mask_i    = s.dep;
    ex_own_bit_i     = s.own;
    ex_pred_taken_i  = s.pt;
    ex_pred_target_i = s.ptgt;
    ex_taken_i       = s.t;
    ex_target_i      = s.tgt;
    ex_fallthru_i    = s.ft;
  endtask

  // Reference: resolve the queue head per the branch rules, then admit the new result.
  task automatic model_update(input stim_t s);
    mentry_t n;
    mentry_t h;
    mentry_t keep [$];
    logic    accept;
    if (s.rst) begin
      mq.delete();
      return;
    end
    accept  = s.valid && (mq.size() < DEPTH);
    n.dep   = s.dep;
    n.own   = s.own;
    n.wrong = (s.pt != s.t) || (s.t && (s.ptgt != s.tgt));
    n.npc   = s.t ? s.tgt : s.ft;
    if (mq.size() > 0) begin
      h = mq.pop_front();
      keep.delete();
      foreach (mq[i]) begin
        mentry_t e;
        e = mq[i];
        if (h.wrong) begin
          if ((e.dep & h.own) == '0) keep.push_back(e);
        end else begin
          e.dep = e.dep & ~h.own;
          keep.push_back(e);
        end
      end
      mq = keep;
      if (h.wrong && ((n.dep & h.own) != '0)) accept = 1'b0;
      if (!h.wrong) n.dep = n.dep & ~h.own;
    end
    if (accept) mq.push_back(n);
  endtask

  task automatic mstep(input stim_t s, input string tag);
    logic [BR_STATE_W-1:0] st;
    logic [BR_MASK_W-1:0]  dep, bb;
    logic                  rv;
    logic [PC_W-1:0]       pc;
    apply(s);
    @(negedge clk);
    st = BR_NONE; dep = '0; bb = '0; rv = 1'b0; pc = '0;
    if (mq.size() > 0) begin
      st  = mq[0].wrong ? BR_PR_WRONG : BR_PR_CORRECT;
      dep = mq[0].dep;
      bb  = mq[0].own;
      rv  = mq[0].wrong;
      pc  = mq[0].wrong ? mq[0].npc : '0;
    end
    cmp_all(tag, st, dep, bb, rv, pc, mq.size() < DEPTH);
    model_update(s);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Directed vectors: expected outputs are those visible during the cycle the inputs are applied.
    tbl[0]  = mk_v(mk_s(0, 1, 5'b00000, 5'b00001, 0, 64'h999, 0, 64'h40,  64'h1004), BR_NONE, 5'b0, 5'b0, 0, 64'h0);
    tbl[1]  = mk_v(idle_s(0), BR_PR_CORRECT, 5'b00000, 5'b00001, 0, 64'h0);
    tbl[2]  = mk_v(idle_s(0), BR_NONE, 5'b0, 5'b0, 0, 64'h0);
    tbl[3]  = mk_v(mk_s(0, 1, 5'b00001, 5'b00010, 1, 64'h100, 1, 64'h200, 64'h2004), BR_NONE, 5'b0, 5'b0, 0, 64'h0);
    tbl[4]  = mk_v(idle_s(0), BR_PR_WRONG, 5'b00001, 5'b00010, 1, 64'h200);
    tbl[5]  = mk_v(idle_s(0), BR_NONE, 5'b0, 5'b0, 0, 64'h0);
    tbl[6]  = mk_v(mk_s(0, 1, 5'b00000, 5'b00001, 0, 64'h0, 1, 64'h300, 64'h3004), BR_NONE, 5'b0, 5'b0, 0, 64'h0);
    tbl[7]  = mk_v(mk_s(0, 1, 5'b00001, 5'b00010, 0, 64'h0, 0, 64'h0, 64'h3104), BR_PR_WRONG, 5'b00000, 5'b00001, 1, 64'h300);
    tbl[8]  = mk_v(idle_s(0), BR_NONE, 5'b0, 5'b0, 0, 64'h0);
    tbl[9]  = mk_v(mk_s(0, 1, 5'b00000, 5'b00001, 1, 64'h500, 1, 64'h500, 64'h4004), BR_NONE, 5'b0, 5'b0, 0, 64'h0);
    tbl[10] = mk_v(mk_s(0, 1, 5'b00001, 5'b00010, 0, 64'h0, 0, 64'h0, 64'h4104), BR_PR_CORRECT, 5'b00000, 5'b00001, 0, 64'h0);
    tbl[11] = mk_v(idle_s(0), BR_PR_CORRECT, 5'b00000, 5'b00010, 0, 64'h0);
    tbl[12] = mk_v(idle_s(0), BR_NONE, 5'b0, 5'b0, 0, 64'h0);
    tbl[13] = mk_v(mk_s(0, 1, 5'b00000, 5'b00100, 1, 64'h700, 0, 64'h0, 64'h6004), BR_NONE, 5'b0, 5'b0, 0, 64'h0);
    tbl[14] = mk_v(mk_s(1, 1, 5'b00000, 5'b01000, 0, 64'h0, 0, 64'h0, 64'h6104), BR_PR_WRONG, 5'b00000, 5'b00100, 1, 64'h6004);
    tbl[15] = mk_v(idle_s(0), BR_NONE, 5'b0, 5'b0, 0, 64'h0);
    tbl[16] = mk_v(idle_s(0), BR_NONE, 5'b0, 5'b0, 0, 64'h0);

    apply(idle_s(1));
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      apply(tbl[i].s);
      @(negedge clk);
      cmp_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].dep, tbl[i].bb, tbl[i].rv, tbl[i].pc, 1'b1);
      @(posedge clk);
      #1;
    end

    // Back-to-back burst: one in, one out per cycle, issued in arrival order.
    mq.delete();
    for (int k = 0; k < 5; k++)
      mstep(mk_s(0, 1, '0, BR_MASK_W'(1) << (k % BR_MASK_W), 0, 64'h0, 0, 64'h0, 64'h5000 + PC_W'(k * 4)),
            $sformatf("burst%0d", k));
    mstep(idle_s(0), "burst_drain0");
    mstep(idle_s(0), "burst_drain1");

    // Random traffic with occasional reset.
    for (int n = 0; n < 600; n++) begin
      stim_t s;
      logic [BR_MASK_W-1:0] own;
      own  = BR_MASK_W'(1) << $urandom_range(0, BR_MASK_W - 1);
      s    = mk_s(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  BR_MASK_W'($urandom) & BR_MASK_W'($urandom) & ~own, own,
                  1'($urandom), PC_W'($urandom_range(1, 2)) << 8,
                  1'($urandom), PC_W'($urandom_range(1, 2)) << 8,
                  PC_W'($urandom) & 64'hFFFC);
      mstep(s, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
